// File: rtl/adc_serial_pkg.sv
// Shared constants for the ADC serial transmitter: default sample and
// frame widths, and the frame FSM state encoding.
package adc_serial_pkg;

  localparam int DATA_W_DEF  = 12;
  localparam int FRAME_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TAIL  = 2'd3;

endpackage

// File: rtl/adc_serial_tx_fifo.sv
// Small sample buffer between producer and the frame FSM.
// Ports: clk, reset (async, active-low), push/din, pop, full, empty, head.
module sample_fifo #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_serial_tx.sv
// Converter-side transmitter of the ADC serial link: buffers samples and
// shifts {zeros, sample} MSB first on SCLK falls while CS is low.
// Ports: clk, reset (async, active-low), data_in/data_valid/data_ready,
//   CS, SCLK (async pins), SDATA, busy, tx_done_tick, abort_tick,
//   underrun_tick.
module adc_serial_tx
  import adc_serial_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int FIFO_DEPTH  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              CS,
  input  logic              SCLK,
  output logic              SDATA,
  output logic              busy,
  output logic              tx_done_tick,
  output logic              abort_tick,
  output logic              underrun_tick
);

  localparam int CW    = $clog2(FRAME_W);
  localparam int PAD_W = FRAME_W - DATA_W;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_W - 1);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cs_q;
  logic                   sclk_q;
  logic                   cs_now;
  logic                   sclk_now;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_fall;

  logic [1:0]         state;
  logic [CW-1:0]      bit_cnt;
  logic [FRAME_W-2:0] shreg;
  logic [DATA_W-1:0]  last_word;
  logic [DATA_W-1:0]  load_word;
  logic [FRAME_W-1:0] frame_word;

  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_pop;

  // Idle-high reset values keep a released reset from faking an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_q      <= cs_now;
      sclk_q    <= sclk_now;
    end
  end

  assign cs_now    = cs_sync[SYNC_STAGES-1];
  assign sclk_now  = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_now;
  assign cs_rise   = ~cs_q & cs_now;
  assign sclk_fall = sclk_q & ~sclk_now;

  assign data_ready = ~fifo_full;
  assign busy       = (state != ST_IDLE);
  assign fifo_pop   = (state == ST_LOAD);

  // An empty buffer resends the previous sample.
  assign load_word  = fifo_empty ? last_word : fifo_head;
  assign frame_word = {{PAD_W{1'b0}}, load_word};

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_valid),
    .din   (data_in),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shreg         <= '0;
      last_word     <= '0;
      SDATA         <= 1'b1;
      tx_done_tick  <= 1'b0;
      abort_tick    <= 1'b0;
      underrun_tick <= 1'b0;
    end else begin
      tx_done_tick  <= 1'b0;
      abort_tick    <= 1'b0;
      underrun_tick <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          SDATA <= 1'b1;
          if (cs_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          last_word     <= load_word;
          underrun_tick <= fifo_empty;
          if (cs_rise) begin
            state      <= ST_IDLE;
            SDATA      <= 1'b1;
            abort_tick <= 1'b1;
          end else begin
            shreg   <= frame_word[FRAME_W-2:0];
            SDATA   <= frame_word[FRAME_W-1];
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state      <= ST_IDLE;
            SDATA      <= 1'b1;
            abort_tick <= 1'b1;
          end else if (sclk_fall) begin
            if (bit_cnt == LAST_BIT) begin
              SDATA        <= 1'b1;
              tx_done_tick <= 1'b1;
              state        <= ST_TAIL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              SDATA   <= shreg[FRAME_W-2];
              shreg   <= {shreg[FRAME_W-3:0], 1'b0};
            end
          end
        end
        ST_TAIL: begin
          SDATA <= 1'b1;
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_tx.sv
// Self-checking bench for adc_serial_tx: directed frames plus random
// pushes/frames against a cycle-level behavioural model.
module tb_adc_serial_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b1;
  logic        data_ready;
  logic        SDATA;
  logic        busy;
  logic        tx_done_tick;
  logic        abort_tick;
  logic        underrun_tick;

  int errors = 0;
  int checks = 0;

  adc_serial_tx dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .CS            (CS),
    .SCLK          (SCLK),
    .SDATA         (SDATA),
    .busy          (busy),
    .tx_done_tick  (tx_done_tick),
    .abort_tick    (abort_tick),
    .underrun_tick (underrun_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: frame phase 0 idle, 1 load, 2 shifting, 3 tail.
  // Pin edges act SYNC_STAGES+1 = 3 clock edges after they are sampled.
  int          ph = 0;
  int          nb = 0;
  logic [11:0] word = '0;
  logic [11:0] mq[$];
  logic [3:0]  hcs = '1;
  logic [3:0]  hsck = '1;
  logic        e_done, e_abort, e_under;
  logic [15:0] fw;
  logic        csf, csr, skf, acc;
  int          n_done = 0;
  int          n_abort = 0;
  int          n_under = 0;

  initial forever begin
    @(posedge clk);
    e_done  = 1'b0;
    e_abort = 1'b0;
    e_under = 1'b0;
    if (!reset) begin
      ph = 0; nb = 0; word = '0;
      mq.delete();
      hcs = '1; hsck = '1;
    end else begin
      hcs  = {hcs[2:0], CS};
      hsck = {hsck[2:0], SCLK};
      csf  = hcs[3] & ~hcs[2];
      csr  = ~hcs[3] & hcs[2];
      skf  = hsck[3] & ~hsck[2];
      acc  = data_valid && (mq.size() < 2);
      case (ph)
        0: if (csf) ph = 1;
        1: begin
          if (mq.size() > 0) word = mq.pop_front();
          else e_under = 1'b1;
          if (csr) begin ph = 0; e_abort = 1'b1; end
          else begin ph = 2; nb = 0; end
        end
        2: begin
          if (csr) begin ph = 0; e_abort = 1'b1; end
          else if (skf) begin
            if (nb == 15) begin ph = 3; e_done = 1'b1; end
            else nb++;
          end
        end
        default: if (csr) ph = 0;
      endcase
      if (acc) mq.push_back(data_in);
    end
    #1;
    fw = {4'b0000, word};
    check("SDATA", SDATA, (ph == 2) ? fw[15-nb] : 1'b1);
    check("busy", busy, ph != 0);
    check("data_ready", data_ready, mq.size() < 2);
    check("tx_done_tick", tx_done_tick, e_done);
    check("abort_tick", abort_tick, e_abort);
    check("underrun_tick", underrun_tick, e_under);
    if (tx_done_tick) n_done++;
    if (abort_tick) n_abort++;
    if (underrun_tick) n_under++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] v);
    data_valid = 1'b1;
    data_in = v;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic drive_dv(input bit sel, input logic [11:0] pv,
                          input bit rnd);
    if (sel) begin
      data_valid = 1'b1;
      data_in = pv;
    end else if (rnd && $urandom_range(3) == 0) begin
      data_valid = 1'b1;
      data_in = 12'($urandom);
    end else begin
      data_valid = 1'b0;
    end
  endtask

  task automatic frame(input int nf, input int half, input int extra,
                       input int push_at, input logic [11:0] pv,
                       input bit rnd, output logic [15:0] rx);
    rx = '0;
    CS = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_dv(i == push_at, pv, rnd);
      @(negedge clk);
    end
    for (int k = 0; k < nf + extra; k++) begin
      if (k < 16) rx = {rx[14:0], SDATA};
      SCLK = 1'b0;
      for (int j = 0; j < half; j++) begin
        drive_dv(1'b0, pv, rnd);
        @(negedge clk);
      end
      SCLK = 1'b1;
      for (int j = 0; j < half; j++) begin
        drive_dv(1'b0, pv, rnd);
        @(negedge clk);
      end
    end
    data_valid = 1'b0;
    CS = 1'b1;
    idle(4);
  endtask

  logic [15:0] rx;
  int d0, a0, u0;

  initial begin
    idle(3);
    reset = 1'b1;
    idle(4);

    d0 = n_done;
    push(12'hABC);
    frame(16, 4, 2, -1, '0, 0, rx);
    check("t1_word", rx, 16'h0ABC);
    check("t1_done", n_done - d0, 1);

    push(12'h123);
    push(12'h456);
    check("t2_full_ready", data_ready, 1'b0);
    push(12'h789);
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t2_word_a", rx, 16'h0123);
    frame(16, 5, 0, -1, '0, 0, rx);
    check("t2_word_b", rx, 16'h0456);

    u0 = n_under;
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t3_word", rx, 16'h0456);
    check("t3_under", n_under - u0, 1);

    push(12'h5A5);
    push(12'h3C3);
    a0 = n_abort;
    frame(7, 4, 0, -1, '0, 0, rx);
    check("t4_sdata_idle", SDATA, 1'b1);
    check("t4_abort", n_abort - a0, 1);
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t4_next_word", rx, 16'h03C3);

    push(12'h111);
    CS = 1'b0;
    idle(6);
    repeat (5) begin
      SCLK = 1'b0; idle(4);
      SCLK = 1'b1; idle(4);
    end
    reset = 1'b0;
    #1;
    check("t5_rst_sdata", SDATA, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", data_ready, 1'b1);
    @(negedge clk);
    CS = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(4);
    u0 = n_under;
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t5_word", rx, 16'h0000);
    check("t5_under", n_under - u0, 1);

    push(12'h222);
    frame(16, 4, 0, 3, 12'h333, 0, rx);
    check("t6_word_a", rx, 16'h0222);
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t6_word_b", rx, 16'h0333);
    frame(16, 4, 0, -1, '0, 0, rx);
    check("t6_resend", rx, 16'h0333);

    repeat (40) begin
      int r;
      r = $urandom_range(9);
      if (r <= 3) begin
        push(12'($urandom));
      end else if (r <= 8) begin
        frame((r == 8) ? $urandom_range(1, 15) : 16,
              $urandom_range(4, 6), $urandom_range(0, 2),
              -1, '0, 1, rx);
      end else begin
        idle($urandom_range(1, 5));
      end
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
